id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised decode stage with an integrated ID/EX pipeline register, register file, branch/jump resolution and hazard detection for the 5-stage MIPS pipeline. It sits between the IF/ID register and the execute stage. It produces the stall and flush controls for the front end and registered control and operands for EX. Unlike the previous decode block, it computes forwarding and stalls internally and keeps saturating performance counters.

## Interface
- XLEN, 32: datapath, PC and immediate width (32 or 64).
- CNT_W, 32: performance counter width.
- HAS_JUMP, 1: 1 enables j (opcode 000010) and jr (R-type, funct 001000); 0 decodes both as nop.

- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- InstrD  in  32  instruction from IF/ID.
- PCPlus4D  in  XLEN  PC+4 from IF/ID.
- ValidD  in  1  IF/ID holds a real instruction.
- RegWriteW, WriteRegW[4:0], ResultW[XLEN]  in  writeback port.
- RegWriteM, MemtoRegM, WriteRegM[4:0], ALUOutM[XLEN]  in  M-stage state.
- StallFD  out  1  hold PC and IF/ID.
- FlushD  out  1  squash IF/ID (taken branch/jump).
- PCSrcD  out  1  redirect PC to PCTargetD.
- PCTargetD  out  XLEN  branch/jump target.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE  out  1 each  registered control.
- ALUControlE  out  3  registered ALU op.
- SrcAE, SrcBE, SignImmE  out  XLEN  registered operands.
- RsE, RtE, RdE  out  5 each  registered register indices.
- StallCount, BranchTakenCount  out  CNT_W  saturating counters.

## Operation
- Decode: lw, sw, addi, andi, ori, beq, bne, R-type (add/sub/and/or/xor/slt), plus j/jr if HAS_JUMP. An unknown opcode is a nop: all control is 0.
- SignImm: InstrD[15:0] sign-extended to XLEN.
- Register file: 32×XLEN, r0 reads 0, and writes to r0 are ignored. Writes occur on the rising edge when RegWriteW=1. A read of a register written in the same cycle returns ResultW (write-through bypass).
- ID operand forwarding: use ALUOutM when RegWriteM && WriteRegM!=0 && WriteRegM==rs (or rt); otherwise use the register file value.
- Branch target: PCPlus4D + (SignImm<<2), modulo 2^XLEN.
- j target: {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00}.
- jr target: the forwarded rs value.
- Taken conditions: beq if A==B; bne if A!=B; j and jr always. When taken, PCSrcD=1 and FlushD=1.
- WriteRegE is internal: RegDstE ? RdE : RtE.
- lwstall: MemtoRegE && ValidE && RtE!=0 && (RtE==rs || RtE==rt).
- branchstall: a branch or jr whose source operand (rs, plus rt for branches) equals either of the following, nonzero:
  - WriteRegE with RegWriteE, or
  - WriteRegM with MemtoRegM.
- Stall = ValidD && (lwstall || branchstall). On a stall:
  - StallFD=1; PCSrcD=0 and FlushD=0.
  - ID/EX loads a bubble: all control 0, ValidE=0.
- No stall: ID/EX loads the decoded control, operands, indices and ValidE=ValidD.
- When ValidD=0: a bubble enters ID/EX and no redirect is issued.
- Counters:
  - StallCount increments each stall cycle.
  - BranchTakenCount increments each cycle with PCSrcD=1.
  - Both saturate at all-ones.

## Timing
- Decode, forwarding, stall and redirect outputs are combinational in the same cycle as InstrD.
- EX outputs appear one cycle after acceptance.
- Reset (RST_N=0 at an edge): all E outputs, counters and registers r1..r31 become 0.
- While RST_N=0: StallFD, FlushD and PCSrcD are forced to 0.
- Reset asserted mid-stall: the stall is abandoned and the pipeline restarts empty.
- Simultaneous lwstall and branchstall: a single stall cycle is counted once.
- A stall persists until the hazard clears, typically 1 cycle for load-use and up to 2 cycles for a branch after a load.

## Structure
- Shared package pipe_pkg holds:
  - opcode and funct localparams;
  - ALU control encodings;
  - a packed ctrl_t struct (RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl, Branch, BranchNE, Jump, JumpReg).
- One sub-module: regfile_p #(XLEN), 2 read ports, 1 write port, with the bypass and reset-clear behaviour above.
- Decode is an always_comb producing ctrl_t; the hazard logic and the ID/EX register live in the top module.

## Test plan
- Reset, then addi r1,r0,5:
  - next cycle RegWriteE=1, ALUSrcE=1, SrcAE=0, SignImmE=5, ValidE=1;
  - all outputs were 0 during reset.
- lw r2,0(r1) then add r3,r2,r1:
  - one cycle StallFD=1, bubble in EX (ValidE=0);
  - add then issues; StallCount=1.
- beq r1,r1,+4 with PCPlus4D=0x100:
  - PCSrcD=1, FlushD=1, PCTargetD=0x110;
  - BranchTakenCount increments.
- add r4,.. in EX followed by bne r4,r0 in ID:
  - stall one cycle;
  - next cycle the bne uses forwarded ALUOutM and resolves correctly.
- Writeback to r5 and read of r5 in the same cycle returns ResultW. A write to r0 leaves r0 reading 0.
- HAS_JUMP=0: jr r31 yields PCSrcD=0 and a nop in EX. HAS_JUMP=1: PCTargetD equals r31.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline: opcodes, functs, ALU ops and the
// decoded control bundle produced by the decode stage.
package pipe_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr  = 6'b001000;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluXor = 3'b011;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_control;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: registered control, operands and register indices
// handed from decode (master) to execute (slave).
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            RegWriteE;
    logic            MemtoRegE;
    logic            MemWriteE;
    logic            ALUSrcE;
    logic            RegDstE;
    logic            ValidE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] SignImmE;
    logic [4:0]      RsE;
    logic [4:0]      RtE;
    logic [4:0]      RdE;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE, ALUControlE,
               SrcAE, SrcBE, SignImmE, RsE, RtE, RdE
    );

    modport slave (
        input RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE, ALUControlE,
              SrcAE, SrcBE, SignImmE, RsE, RtE, RdE
    );
endinterface

// File: rtl/id_ex_stage_regfile.sv
// 32 x XLEN register file, two read ports and one write port; r0 reads zero and a read
// of the register being written this cycle returns the write data.
module regfile_p #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] rf_q [32];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            rf_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = rf_q[ra1_i];
        if (ra1_i == 5'd0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
    end

    always_comb begin
        rd2_o = rf_q[ra2_i];
        if (ra2_i == 5'd0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with register file, ID-stage forwarding, branch/jump resolution, hazard
// stalls, the ID/EX pipeline register and saturating stall/taken-branch counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = 32,
    parameter bit          HAS_JUMP = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      InstrD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic             ValidD,
    input  logic             RegWriteW,
    input  logic [4:0]       WriteRegW,
    input  logic [XLEN-1:0]  ResultW,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic [4:0]       WriteRegM,
    input  logic [XLEN-1:0]  ALUOutM,
    output logic             StallFD,
    output logic             FlushD,
    output logic             PCSrcD,
    output logic [XLEN-1:0]  PCTargetD,
    id_ex_stage_if.master    ex_if,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] BranchTakenCount
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            memto_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_dst;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [XLEN-1:0] sign_imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
    } ex_t;

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd, write_reg_e;
    logic [XLEN-1:0] sign_imm, rf_a, rf_b, src_a, src_b, branch_target, jump_target;
    logic            dep_rs, dep_rt, lw_stall, branch_stall, stall, take;
    ctrl_t           ctrl;
    ex_t             ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, br_cnt_d, br_cnt_q;

    assign op       = InstrD[31:26];
    assign funct    = InstrD[5:0];
    assign rs       = InstrD[25:21];
    assign rt       = InstrD[20:16];
    assign rd       = InstrD[15:11];
    assign sign_imm = {{(XLEN-16){InstrD[15]}}, InstrD[15:0]};

    always_comb begin
        ctrl = CtrlNop;
        case (op)
            OpLw:   begin
                ctrl.reg_write = 1'b1; ctrl.memto_reg = 1'b1;
                ctrl.alu_src = 1'b1;   ctrl.alu_control = AluAdd;
            end
            OpSw:   begin
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = AluAdd;
            end
            OpAddi: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = AluAdd;
            end
            OpAndi: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = AluAnd;
            end
            OpOri:  begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = AluOr;
            end
            OpBeq:  begin ctrl.branch = 1'b1;    ctrl.alu_control = AluSub; end
            OpBne:  begin ctrl.branch_ne = 1'b1; ctrl.alu_control = AluSub; end
            OpJ:    ctrl.jump = HAS_JUMP;
            OpRtype: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FnAdd:   ctrl.alu_control = AluAdd;
                    FnSub:   ctrl.alu_control = AluSub;
                    FnAnd:   ctrl.alu_control = AluAnd;
                    FnOr:    ctrl.alu_control = AluOr;
                    FnXor:   ctrl.alu_control = AluXor;
                    FnSlt:   ctrl.alu_control = AluSlt;
                    FnJr:    begin ctrl = CtrlNop; ctrl.jump_reg = HAS_JUMP; end
                    default: ctrl = CtrlNop;
                endcase
            end
            default: ctrl = CtrlNop;
        endcase
    end

    regfile_p #(.XLEN(XLEN)) u_regfile (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .ra1_i  (rs),
        .ra2_i  (rt),
        .rd1_o  (rf_a),
        .rd2_o  (rf_b),
        .we_i   (RegWriteW),
        .wa_i   (WriteRegW),
        .wd_i   (ResultW)
    );

    // ALUOutM bypass lets branches resolve in ID against an ALU result one stage ahead.
    assign src_a = (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == rs)) ? ALUOutM : rf_a;
    assign src_b = (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == rt)) ? ALUOutM : rf_b;

    assign write_reg_e = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

    assign dep_rs = (rs != 5'd0) && ((ex_q.reg_write && (write_reg_e == rs)) ||
                                     (MemtoRegM && (WriteRegM == rs)));
    assign dep_rt = (rt != 5'd0) && ((ex_q.reg_write && (write_reg_e == rt)) ||
                                     (MemtoRegM && (WriteRegM == rt)));

    assign lw_stall     = ex_q.memto_reg && ex_q.valid && (ex_q.rt != 5'd0) &&
                          ((ex_q.rt == rs) || (ex_q.rt == rt));
    assign branch_stall = ((ctrl.branch || ctrl.branch_ne) && (dep_rs || dep_rt)) ||
                          (ctrl.jump_reg && dep_rs);
    assign stall        = ValidD && (lw_stall || branch_stall);

    assign take = ValidD && !stall && ((ctrl.branch && (src_a == src_b)) ||
                                       (ctrl.branch_ne && (src_a != src_b)) ||
                                       ctrl.jump || ctrl.jump_reg);

    assign StallFD = RST_N && stall;
    assign PCSrcD  = RST_N && take;
    assign FlushD  = RST_N && take;

    assign branch_target = PCPlus4D + (sign_imm << 2);
    assign jump_target   = {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00};

    always_comb begin
        PCTargetD = branch_target;
        if (ctrl.jump) begin
            PCTargetD = jump_target;
        end else if (ctrl.jump_reg) begin
            PCTargetD = src_a;
        end
    end

    always_comb begin
        ex_d = '0;
        if (ValidD && !stall) begin
            ex_d.valid       = 1'b1;
            ex_d.reg_write   = ctrl.reg_write;
            ex_d.memto_reg   = ctrl.memto_reg;
            ex_d.mem_write   = ctrl.mem_write;
            ex_d.alu_src     = ctrl.alu_src;
            ex_d.reg_dst     = ctrl.reg_dst;
            ex_d.alu_control = ctrl.alu_control;
            ex_d.src_a       = src_a;
            ex_d.src_b       = src_b;
            ex_d.sign_imm    = sign_imm;
            ex_d.rs          = rs;
            ex_d.rt          = rt;
            ex_d.rd          = rd;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        br_cnt_d    = br_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (take && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            br_cnt_q    <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            br_cnt_q    <= br_cnt_d;
        end
    end

    assign ex_if.ValidE      = ex_q.valid;
    assign ex_if.RegWriteE   = ex_q.reg_write;
    assign ex_if.MemtoRegE   = ex_q.memto_reg;
    assign ex_if.MemWriteE   = ex_q.mem_write;
    assign ex_if.ALUSrcE     = ex_q.alu_src;
    assign ex_if.RegDstE     = ex_q.reg_dst;
    assign ex_if.ALUControlE = ex_q.alu_control;
    assign ex_if.SrcAE       = ex_q.src_a;
    assign ex_if.SrcBE       = ex_q.src_b;
    assign ex_if.SignImmE    = ex_q.sign_imm;
    assign ex_if.RsE         = ex_q.rs;
    assign ex_if.RtE         = ex_q.rt;
    assign ex_if.RdE         = ex_q.rd;

    assign StallCount       = stall_cnt_q;
    assign BranchTakenCount = br_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random instruction streams, all checked
// against an instruction-level reference model of decode, hazards and counters.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [31:0]      InstrD;
    logic [XLEN-1:0]  PCPlus4D;
    logic             ValidD, RegWriteW, RegWriteM, MemtoRegM;
    logic [4:0]       WriteRegW, WriteRegM;
    logic [XLEN-1:0]  ResultW, ALUOutM;
    logic             StallFD, FlushD, PCSrcD;
    logic [XLEN-1:0]  PCTargetD;
    logic [CNT_W-1:0] StallCount, BranchTakenCount;
    logic             StallFD_nj, FlushD_nj, PCSrcD_nj;
    logic [XLEN-1:0]  PCTargetD_nj;
    logic [CNT_W-1:0] StallCount_nj, BranchTakenCount_nj;

    always #5 CLK = ~CLK;

    id_ex_stage_if #(.XLEN(XLEN)) ex_bus ();
    id_ex_stage_if #(.XLEN(XLEN)) ex_nj ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .HAS_JUMP(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .StallFD(StallFD), .FlushD(FlushD), .PCSrcD(PCSrcD),
        .PCTargetD(PCTargetD), .ex_if(ex_bus), .StallCount(StallCount),
        .BranchTakenCount(BranchTakenCount)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .HAS_JUMP(1'b0)) dut_nj (
        .CLK(CLK), .RST_N(RST_N), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .StallFD(StallFD_nj), .FlushD(FlushD_nj), .PCSrcD(PCSrcD_nj),
        .PCTargetD(PCTargetD_nj), .ex_if(ex_nj), .StallCount(StallCount_nj),
        .BranchTakenCount(BranchTakenCount_nj)
    );

    typedef enum int {KNop, KLw, KSw, KAddi, KAndi, KOri, KBeq, KBne,
                      KAdd, KSub, KAnd, KOr, KXor, KSlt, KJ, KJr} kind_e;

    typedef struct {
        logic            valid, reg_write, memto_reg, mem_write, alu_src, reg_dst;
        logic [2:0]      alu;
        logic [XLEN-1:0] a, b, imm;
        logic [4:0]      rs, rt, rd;
    } m_ex_t;

    logic [XLEN-1:0] m_regs [32];
    m_ex_t           m_ex, m_ex_next;
    int unsigned     m_stall_cnt, m_br_cnt;
    logic            e_stall, e_taken;
    logic [XLEN-1:0] e_target;
    int              checks = 0;
    int              errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ins, input bit has_jump);
        case (ins[31:26])
            6'b100011: return KLw;
            6'b101011: return KSw;
            6'b001000: return KAddi;
            6'b001100: return KAndi;
            6'b001101: return KOri;
            6'b000100: return KBeq;
            6'b000101: return KBne;
            6'b000010: return has_jump ? KJ : KNop;
            6'b000000: begin
                case (ins[5:0])
                    6'b100000: return KAdd;
                    6'b100010: return KSub;
                    6'b100100: return KAnd;
                    6'b100101: return KOr;
                    6'b100110: return KXor;
                    6'b101010: return KSlt;
                    6'b001000: return has_jump ? KJr : KNop;
                    default:   return KNop;
                endcase
            end
            default: return KNop;
        endcase
    endfunction

    // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl}
    function automatic logic [7:0] ctl_of(input kind_e k);
        case (k)
            KLw:        return {5'b11010, AluAdd};
            KSw:        return {5'b00110, AluAdd};
            KAddi:      return {5'b10010, AluAdd};
            KAndi:      return {5'b10010, AluAnd};
            KOri:       return {5'b10010, AluOr};
            KBeq, KBne: return {5'b00000, AluSub};
            KAdd:       return {5'b10001, AluAdd};
            KSub:       return {5'b10001, AluSub};
            KAnd:       return {5'b10001, AluAnd};
            KOr:        return {5'b10001, AluOr};
            KXor:       return {5'b10001, AluXor};
            KSlt:       return {5'b10001, AluSlt};
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] r);
        if (RegWriteM && r != 0 && WriteRegM == r) return ALUOutM;
        if (r == 0) return '0;
        if (RegWriteW && WriteRegW == r) return ResultW;
        return m_regs[r];
    endfunction

    function automatic logic busy(input logic [4:0] r, input logic [4:0] wre);
        return (r != 0) && ((m_ex.reg_write && wre == r) || (MemtoRegM && WriteRegM == r));
    endfunction

    task automatic model_comb();
        kind_e           k;
        logic [4:0]      rs, rt, wre;
        logic [XLEN-1:0] a, b, imm;
        logic            lw_hz, br_hz, hazard;
        k   = classify(InstrD, 1'b1);
        rs  = InstrD[25:21];
        rt  = InstrD[20:16];
        a   = fwd(rs);
        b   = fwd(rt);
        imm = XLEN'($signed(InstrD[15:0]));
        wre = m_ex.reg_dst ? m_ex.rd : m_ex.rt;
        lw_hz = m_ex.valid && m_ex.memto_reg && m_ex.rt != 0 &&
                (m_ex.rt == rs || m_ex.rt == rt);
        br_hz = 1'b0;
        if (k == KBeq || k == KBne) br_hz = busy(rs, wre) || busy(rt, wre);
        if (k == KJr) br_hz = busy(rs, wre);
        hazard  = ValidD && (lw_hz || br_hz);
        e_stall = RST_N && hazard;
        e_taken = RST_N && ValidD && !hazard &&
                  ((k == KBeq && a == b) || (k == KBne && a != b) || k == KJ || k == KJr);
        case (k)
            KJ:      e_target = {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00};
            KJr:     e_target = a;
            default: e_target = PCPlus4D + imm * 4;
        endcase
        m_ex_next = '{default: '0};
        if (ValidD && !hazard) begin
            m_ex_next.valid = 1'b1;
            {m_ex_next.reg_write, m_ex_next.memto_reg, m_ex_next.mem_write,
             m_ex_next.alu_src, m_ex_next.reg_dst, m_ex_next.alu} = ctl_of(k);
            m_ex_next.a   = a;
            m_ex_next.b   = b;
            m_ex_next.imm = imm;
            m_ex_next.rs  = rs;
            m_ex_next.rt  = rt;
            m_ex_next.rd  = InstrD[15:11];
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_ex        = '{default: '0};
            m_stall_cnt = 0;
            m_br_cnt    = 0;
        end else begin
            if (e_stall && m_stall_cnt < CntMax) m_stall_cnt++;
            if (e_taken && m_br_cnt < CntMax) m_br_cnt++;
            if (RegWriteW && WriteRegW != 0) m_regs[WriteRegW] = ResultW;
            m_ex = m_ex_next;
        end
    endtask

    task automatic settle_and_check();
        #3;
        model_comb();
        check_eq("StallFD", StallFD, e_stall);
        check_eq("PCSrcD", PCSrcD, e_taken);
        check_eq("FlushD", FlushD, e_taken);
        if (e_taken) check_eq("PCTargetD", PCTargetD, e_target);
    endtask

    task automatic clock_and_check();
        @(posedge CLK);
        model_edge();
        #1;
        check_eq("ValidE", ex_bus.ValidE, m_ex.valid);
        check_eq("RegWriteE", ex_bus.RegWriteE, m_ex.reg_write);
        check_eq("MemtoRegE", ex_bus.MemtoRegE, m_ex.memto_reg);
        check_eq("MemWriteE", ex_bus.MemWriteE, m_ex.mem_write);
        check_eq("ALUSrcE", ex_bus.ALUSrcE, m_ex.alu_src);
        check_eq("RegDstE", ex_bus.RegDstE, m_ex.reg_dst);
        check_eq("ALUControlE", ex_bus.ALUControlE, m_ex.alu);
        if (m_ex.valid) begin
            check_eq("SrcAE", ex_bus.SrcAE, m_ex.a);
            check_eq("SrcBE", ex_bus.SrcBE, m_ex.b);
            check_eq("SignImmE", ex_bus.SignImmE, m_ex.imm);
            check_eq("RsE", ex_bus.RsE, m_ex.rs);
            check_eq("RtE", ex_bus.RtE, m_ex.rt);
            check_eq("RdE", ex_bus.RdE, m_ex.rd);
        end
        check_eq("StallCount", StallCount, m_stall_cnt);
        check_eq("BranchTakenCount", BranchTakenCount, m_br_cnt);
    endtask

    task automatic set_idle();
        RST_N = 1'b1; ValidD = 1'b0; InstrD = '0; PCPlus4D = 32'h40;
        RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = '0; ALUOutM = '0;
    endtask

    task automatic issue(input logic [31:0] ins);
        set_idle();
        ValidD = 1'b1;
        InstrD = ins;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs  = 5'($urandom_range(0, 7));
        logic [4:0]  rt  = 5'($urandom_range(0, 7));
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        logic [5:0]  fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                 6'b101010};
        logic [5:0]  ops [7] = '{6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
                                 6'b000100, 6'b000101};
        int sel = int'($urandom_range(0, 15));
        if (sel < 7) return {ops[sel], rs, rt, imm};
        if (sel < 13) return {6'b000000, rs, rt, rd, 5'd0, fns[sel-7]};
        if (sel == 13) return {6'b000010, 26'($urandom)};
        if (sel == 14) return {6'b000000, rs, 15'd0, 6'b001000};
        return {6'b111111, rs, rt, imm};
    endfunction

    function automatic logic [XLEN-1:0] rand_val();
        if ($urandom_range(0, 1) == 0) return XLEN'($urandom_range(0, 3));
        return XLEN'($urandom);
    endfunction

    initial begin
        set_idle();
        RST_N  = 1'b0;
        ValidD = 1'b1;
        InstrD = {6'b000100, 5'd0, 5'd0, 16'd3};
        @(posedge CLK);
        model_edge();
        #1;
        // Reset cycle with a would-be-taken beq present
        settle_and_check();
        check_eq("rst_PCSrcD", PCSrcD, 1'b0);
        check_eq("rst_FlushD", FlushD, 1'b0);
        clock_and_check();
        check_eq("rst_ValidE", ex_bus.ValidE, 1'b0);
        check_eq("rst_StallCount", StallCount, 0);

        issue({6'b001000, 5'd0, 5'd1, 16'd5});           // addi r1,r0,5
        settle_and_check();
        clock_and_check();
        check_eq("addi_RegWriteE", ex_bus.RegWriteE, 1'b1);
        check_eq("addi_ALUSrcE", ex_bus.ALUSrcE, 1'b1);
        check_eq("addi_SrcAE", ex_bus.SrcAE, 0);
        check_eq("addi_SignImmE", ex_bus.SignImmE, 5);
        check_eq("addi_ValidE", ex_bus.ValidE, 1'b1);

        issue({6'b100011, 5'd1, 5'd2, 16'd0});           // lw r2,0(r1)
        settle_and_check();
        clock_and_check();
        issue({6'b000000, 5'd2, 5'd1, 5'd3, 5'd0, 6'b100000});  // add r3,r2,r1
        settle_and_check();
        check_eq("lu_StallFD", StallFD, 1'b1);
        clock_and_check();
        check_eq("lu_bubble", ex_bus.ValidE, 1'b0);
        check_eq("lu_StallCount", StallCount, 1);
        settle_and_check();
        check_eq("lu_release", StallFD, 1'b0);
        clock_and_check();
        check_eq("lu_add_ValidE", ex_bus.ValidE, 1'b1);

        issue({6'b000100, 5'd1, 5'd1, 16'd4});           // beq r1,r1,+4
        PCPlus4D = 32'h100;
        settle_and_check();
        check_eq("beq_PCSrcD", PCSrcD, 1'b1);
        check_eq("beq_FlushD", FlushD, 1'b1);
        check_eq("beq_PCTargetD", PCTargetD, 32'h110);
        clock_and_check();
        check_eq("beq_count", BranchTakenCount, 1);

        issue({6'b000000, 5'd1, 5'd1, 5'd4, 5'd0, 6'b100000});  // add r4,r1,r1
        settle_and_check();
        clock_and_check();
        issue({6'b000101, 5'd4, 5'd0, 16'd8});           // bne r4,r0,+8
        settle_and_check();
        check_eq("bne_stall", StallFD, 1'b1);
        clock_and_check();
        RegWriteM = 1'b1; WriteRegM = 5'd4; ALUOutM = 32'd10;
        settle_and_check();
        check_eq("bne_nostall", StallFD, 1'b0);
        check_eq("bne_taken", PCSrcD, 1'b1);
        clock_and_check();
        check_eq("bne_stallcount", StallCount, 2);

        issue({6'b000000, 5'd5, 5'd0, 5'd6, 5'd0, 6'b100000});  // add r6,r5,r0
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hABCD;
        settle_and_check();
        clock_and_check();
        check_eq("wb_bypass", ex_bus.SrcAE, 32'hABCD);
        issue({6'b000000, 5'd0, 5'd5, 5'd7, 5'd0, 6'b100000});  // add r7,r0,r5
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h77;
        settle_and_check();
        clock_and_check();
        check_eq("r0_zero", ex_bus.SrcAE, 0);
        check_eq("r5_stored", ex_bus.SrcBE, 32'hABCD);

        set_idle();
        RegWriteW = 1'b1; WriteRegW = 5'd31; ResultW = 32'h2468;
        settle_and_check();
        clock_and_check();
        issue({6'b000000, 5'd31, 15'd0, 6'b001000});     // jr r31
        settle_and_check();
        check_eq("jr_PCSrcD", PCSrcD, 1'b1);
        check_eq("jr_PCTargetD", PCTargetD, 32'h2468);
        check_eq("nj_jr_PCSrcD", PCSrcD_nj, 1'b0);
        clock_and_check();
        check_eq("nj_jr_ValidE", ex_nj.ValidE, 1'b1);
        check_eq("nj_jr_RegWriteE", ex_nj.RegWriteE, 1'b0);
        check_eq("nj_jr_ALUControlE", ex_nj.ALUControlE, 3'b000);

        issue({6'b000010, 26'h0000123});                 // j
        PCPlus4D = 32'hA000_0004;
        settle_and_check();
        check_eq("j_PCTargetD", PCTargetD, 32'hA000_048C);
        clock_and_check();

        // Reset while a load-use stall is pending
        issue({6'b100011, 5'd1, 5'd2, 16'd0});
        settle_and_check();
        clock_and_check();
        issue({6'b000000, 5'd2, 5'd2, 5'd3, 5'd0, 6'b100000});
        RST_N = 1'b0;
        settle_and_check();
        check_eq("rststall_StallFD", StallFD, 1'b0);
        clock_and_check();
        check_eq("rststall_ValidE", ex_bus.ValidE, 1'b0);
        check_eq("rststall_count", StallCount, 0);
        RST_N = 1'b1;
        settle_and_check();
        check_eq("rststall_restart", StallFD, 1'b0);
        clock_and_check();

        for (int n = 0; n < 1500; n++) begin
            RST_N     = ($urandom_range(0, 119) != 0);
            ValidD    = ($urandom_range(0, 7) != 0);
            InstrD    = rand_instr();
            PCPlus4D  = XLEN'($urandom) & ~XLEN'(3);
            RegWriteW = 1'($urandom_range(0, 1));
            WriteRegW = 5'($urandom_range(0, 7));
            ResultW   = rand_val();
            RegWriteM = 1'($urandom_range(0, 1));
            MemtoRegM = ($urandom_range(0, 3) == 0);
            WriteRegM = 5'($urandom_range(0, 7));
            ALUOutM   = rand_val();
            settle_and_check();
            clock_and_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
